// File: rtl/instruction_fetch_if.sv
// IF stage bus: instruction-memory port, hazard/redirect controls, IF/ID outputs.
// Counters are live only when IF_PERF_CNT_EN is defined in the stage.
interface instruction_fetch_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32,
  parameter int PC_W        = 32
);
  logic [INS_ADDRESS-1:0] imem_ra;
  logic [INS_W-1:0]       imem_rd;
  logic                   stall;
  logic                   flush;
  logic                   redirect;
  logic [PC_W-1:0]        redirect_pc;
  logic [PC_W-1:0]        if_pc;
  logic [PC_W-1:0]        if_pc4;
  logic [INS_W-1:0]       if_inst;
  logic                   if_valid;
  logic                   if_misalign;
  logic [31:0]            fetch_count;
  logic [31:0]            redirect_count;

  modport slave (
    output imem_ra, if_pc, if_pc4, if_inst,
    output if_valid, if_misalign,
    output fetch_count, redirect_count,
    input  imem_rd, stall, flush,
    input  redirect, redirect_pc
  );

  modport master (
    input  imem_ra, if_pc, if_pc4, if_inst,
    input  if_valid, if_misalign,
    input  fetch_count, redirect_count,
    output imem_rd, stall, flush,
    output redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, imem address, IF/ID register.
// Optional perf counters enabled by IF_PERF_CNT_EN.
module instruction_fetch #(
  parameter int              INS_ADDRESS = 9,
  parameter int              INS_W       = 32,
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input logic               clk,
  input logic               reset,
  instruction_fetch_if.slave bus
);

  localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc4;
  logic [PC_W-1:0]  w_tgt;
  logic             w_bubble;
  logic             w_load;
  logic             r_mis_pend;
  logic [PC_W-1:0]  r_if_pc;
  logic [PC_W-1:0]  r_if_pc4;
  logic [INS_W-1:0] r_if_inst;
  logic             r_if_valid;
  logic             r_if_mis;

  assign w_pc4    = r_pc + PC_W'(4);
  assign w_tgt    = {bus.redirect_pc[PC_W-1:2], 2'b00};
  assign w_bubble = bus.redirect | bus.flush;
  assign w_load   = ~w_bubble & ~bus.stall;

  assign bus.imem_ra     = r_pc[INS_ADDRESS-1:0];
  assign bus.if_pc       = r_pc_out();
  assign bus.if_pc4      = r_if_pc4;
  assign bus.if_inst     = r_if_inst;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_misalign = r_if_mis;

  function automatic logic [PC_W-1:0] r_pc_out();
    return r_if_pc;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc <= w_tgt;
    end else if (!bus.stall) begin
      r_pc <= w_pc4;
    end
  end

  // Misalignment flag follows the redirect to exactly one loaded word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mis_pend <= 1'b0;
    end else if (bus.redirect) begin
      r_mis_pend <= |bus.redirect_pc[1:0];
    end else if (w_load) begin
      r_mis_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_pc    <= RESET_PC;
      r_if_pc4   <= RESET_PC + PC_W'(4);
      r_if_inst  <= NOP;
      r_if_valid <= 1'b0;
      r_if_mis   <= 1'b0;
    end else if (w_bubble) begin
      r_if_inst  <= NOP;
      r_if_valid <= 1'b0;
      r_if_mis   <= 1'b0;
    end else if (!bus.stall) begin
      r_if_pc    <= r_pc;
      r_if_pc4   <= w_pc4;
      r_if_inst  <= bus.imem_rd;
      r_if_valid <= 1'b1;
      r_if_mis   <= r_mis_pend;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redir_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (w_load && r_fetch_cnt != '1)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (bus.redirect && r_redir_cnt != '1)
        r_redir_cnt <= r_redir_cnt + 32'd1;
    end
  end

  assign bus.fetch_count    = r_fetch_cnt;
  assign bus.redirect_count = r_redir_cnt;
`else
  assign bus.fetch_count    = '0;
  assign bus.redirect_count = '0;
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch (IF) stage of the five-stage RISC-V pipeline. Holds the program counter and drives the byte read address of the combinational instruction memory. Captures the returned word into the IF/ID pipeline register. Applies stall, flush and branch/jump redirect requests from the hazard unit and the execute stage, and presents the fetched instruction with its PC and PC+4 to decode.

## Interface
- INS_ADDRESS, 9: width of the instruction-memory byte address (word index = bits [INS_ADDRESS-1:2])
- INS_W, 32: instruction width
- PC_W, 32: program counter width
- RESET_PC, 32'h0: PC value loaded on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_ra  out  INS_ADDRESS  instruction-memory read address, equal to pc[INS_ADDRESS-1:0]
- imem_rd  in  INS_W  instruction-memory read data, combinational from imem_ra
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  replace the IF/ID contents with a bubble on this edge
- redirect  in  1  taken branch, jal or jalr resolved in EX
- redirect_pc  in  PC_W  redirect target byte address
- if_pc  out  PC_W  PC of the instruction in IF/ID
- if_pc4  out  PC_W  if_pc + 4
- if_inst  out  INS_W  instruction in IF/ID
- if_valid  out  1  IF/ID holds a real instruction
- if_misalign  out  1  instruction was fetched from a misaligned redirect target
- fetch_count  out  32  valid instructions delivered (see Configuration)
- redirect_count  out  32  redirects accepted (see Configuration)

## Operation
- PC register next-value priority:
  - redirect: {redirect_pc[PC_W-1:2], 2'b00}
  - else stall: hold
  - else pc + 4, modulo 2^PC_W
- imem_ra is combinational from pc. The address wraps naturally by truncation, so there is no out-of-range detection.
- IF/ID register next-value priority:
  - redirect or flush: bubble, with if_inst = 32'h00000013 (addi x0,x0,0), if_valid = 0, if_misalign = 0, and if_pc/if_pc4 unchanged
  - else stall: hold all fields
  - else load if_inst = imem_rd, if_pc = pc, if_pc4 = pc + 4, if_valid = 1, if_misalign = mis_pend
- mis_pend is an internal flag:
  - set on a redirect with redirect_pc[1:0] != 0
  - cleared when IF/ID loads (the flag attaches to exactly one instruction)
  - a redirect with an aligned target clears it
- Stall with redirect in the same cycle: redirect wins for both PC and IF/ID.
- Stall with flush in the same cycle: PC holds and IF/ID takes a bubble. The held PC is refetched next cycle.
- if_pc4 is stored, not recomputed, so it stays consistent with if_pc during stall.

## Timing
- Reset (asynchronous assert, synchronous release to clk) drives:
  - pc = RESET_PC, so imem_ra = RESET_PC[INS_ADDRESS-1:0]
  - if_inst = 32'h00000013, if_valid = 0, if_pc = RESET_PC, if_pc4 = RESET_PC + 4, if_misalign = 0
  - mis_pend = 0, and both counters = 0
- Fetch latency: the word at PC p appears on if_inst one clk edge after pc = p.
- Redirect asserted in cycle n:
  - the target is on imem_ra in cycle n+1
  - the bubble is in IF/ID in cycle n+1
  - the target instruction is in IF/ID in cycle n+2
- Reset mid-operation discards all in-flight state immediately, including mis_pend.
- No handshake: stall, flush and redirect are sampled every edge. Each is level-sensitive and acts once per cycle it is high.

## Configuration
- Macro: IF_PERF_CNT_EN
- Defined:
  - fetch_count increments on every edge where IF/ID loads with if_valid = 1
  - redirect_count increments on every edge where redirect = 1
  - both counters saturate at 32'hFFFFFFFF and reset to 0
- Undefined: both ports are tied to 32'h0, no counter flops exist, and the ports remain present.

## Test plan
- Reset, then release with imem preloaded (word0 = 32'h00007033, word1 = 32'h00100093) -> cycle after release: if_valid = 0, imem_ra = 0; next edge: if_inst = 32'h00007033, if_pc = 0; following edge: if_inst = 32'h00100093, if_pc = 4, if_pc4 = 8.
- Stall high for 2 cycles with if_pc = 8 -> if_inst, if_pc and imem_ra are unchanged for 2 cycles; the first edge after release loads pc = 12's word.
- redirect = 1, redirect_pc = 32'h30 while pc = 16 -> next cycle: if_valid = 0, imem_ra = 9'h030; following cycle: if_pc = 32'h30, if_valid = 1.
- redirect_pc = 32'h2E -> pc = 32'h2C, and the next loaded instruction has if_misalign = 1; the one after it has if_misalign = 0.
- stall and flush together at pc = 20 -> IF/ID bubble (if_inst = 32'h00000013), pc stays 20, and the next edge loads the word at 20. With IF_PERF_CNT_EN defined, fetch_count does not increment on the bubble edge.
- Assert reset mid-stream at pc = 32'h1C with mis_pend set -> outputs return to reset values immediately; after release the fetch resumes at RESET_PC with if_misalign = 0 and counters = 0.
